// File: rtl/definitions.sv
// Shared opcode constants, FSM state type and small helpers for the sequential ALU.
package definitions;

  localparam int OP_W = 5;

  localparam logic [OP_W-1:0] kADD = 5'd0;
  localparam logic [OP_W-1:0] kSUB = 5'd1;
  localparam logic [OP_W-1:0] kAND = 5'd2;
  localparam logic [OP_W-1:0] kXOR = 5'd3;
  localparam logic [OP_W-1:0] kSLL = 5'd4;
  localparam logic [OP_W-1:0] kSRL = 5'd5;
  localparam logic [OP_W-1:0] kCMP = 5'd6;
  localparam logic [OP_W-1:0] kMOV = 5'd7;
  localparam logic [OP_W-1:0] kLD  = 5'd8;
  localparam logic [OP_W-1:0] kADC = 5'd9;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} alu_state_t;

  function automatic logic is_shift_op(input logic [OP_W-1:0] op);
    return (op == kSLL) || (op == kSRL);
  endfunction

endpackage

// File: rtl/alu_shifter.sv
// Iterative one-bit-per-cycle logical shifter; exposes the value and bit the next step produces.
// done is high in the cycle whose rising edge performs the final shift; reset discards any shift.
module alu_shifter #(
  parameter  int W   = 8,
  localparam int SHW = $clog2(W)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic           dir,
  input  logic [SHW-1:0] amount,
  input  logic [W-1:0]   data_in,
  output logic           done,
  output logic [W-1:0]   data_nxt,
  output logic           last_nxt
);

  logic [W-1:0]   sh_q;
  logic [SHW-1:0] cnt_q;
  logic           dir_q;

  // dir=1 shifts right; the bit leaving the register is what becomes the carry
  always_comb begin
    data_nxt = dir_q ? (sh_q >> 1) : (sh_q << 1);
    last_nxt = dir_q ? sh_q[0] : sh_q[W-1];
    done     = (cnt_q == SHW'(1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh_q  <= '0;
      cnt_q <= '0;
      dir_q <= 1'b0;
    end else if (load) begin
      sh_q  <= data_in;
      cnt_q <= amount;
      dir_q <= dir;
    end else if (cnt_q != '0) begin
      sh_q  <= data_nxt;
      cnt_q <= cnt_q - SHW'(1);
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU with persistent co/lt/z flags; 1-cycle ops, shifts take n cycles (bit per edge).
// Valid/ready both sides: result and flags hold in DONE until taken; in_ready is low while shifting.
module seq_alu
  import definitions::*;
#(
  parameter  int W   = 8,
  localparam int SHW = $clog2(W)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OP_W-1:0] op,
  input  logic [W-1:0]    in_a,
  input  logic [W-1:0]    in_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    rslt,
  output logic            co,
  output logic            lt,
  output logic            z
);

  alu_state_t     state, state_nxt;
  logic           accept;
  logic           start_shift;
  logic [SHW-1:0] shamt;

  logic [W:0]     sum;
  logic [W-1:0]   dp_rslt;
  logic           dp_co, dp_lt, dp_z;

  logic           sh_fin, sh_done, sh_last;
  logic [W-1:0]   sh_nxt;

  assign shamt       = in_b[SHW-1:0];
  assign in_ready    = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept      = in_valid && in_ready;
  assign start_shift = accept && is_shift_op(op) && (shamt != '0);
  assign out_valid   = (state == DONE);
  assign sh_done     = (state == SHIFT) && sh_fin;

  alu_shifter #(.W(W)) u_shifter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (start_shift),
    .dir      (op == kSRL),
    .amount   (shamt),
    .data_in  (in_a),
    .done     (sh_fin),
    .data_nxt (sh_nxt),
    .last_nxt (sh_last)
  );

  // Single-cycle datapath; ADC reads the registered co, which already holds any prior ADD's carry
  always_comb begin
    sum     = '0;
    dp_rslt = '0;
    dp_co   = co;
    dp_lt   = lt;
    dp_z    = z;
    case (op)
      kADD: begin
        sum     = {1'b0, in_a} + {1'b0, in_b};
        dp_rslt = sum[W-1:0];
        dp_co   = sum[W];
        dp_z    = (sum[W-1:0] == '0);
      end
      kADC: begin
        sum     = {1'b0, in_a} + {1'b0, in_b} + {{W{1'b0}}, co};
        dp_rslt = sum[W-1:0];
        dp_co   = sum[W];
        dp_z    = (sum[W-1:0] == '0);
      end
      kSUB: begin
        sum     = {1'b0, in_a} + {1'b0, ~in_b} + (W+1)'(1);
        dp_rslt = sum[W-1:0];
        dp_co   = sum[W];
        dp_z    = (sum[W-1:0] == '0);
      end
      kAND: begin
        dp_rslt = in_a & in_b;
        dp_z    = ((in_a & in_b) == '0);
      end
      kXOR: begin
        dp_rslt = in_a ^ in_b;
        dp_z    = ((in_a ^ in_b) == '0);
      end
      kSLL, kSRL: begin
        // only reached as a completing op for a zero shift amount
        dp_rslt = in_a;
        dp_z    = (in_a == '0);
      end
      kCMP: begin
        dp_z  = (in_a == in_b);
        dp_lt = (in_a < in_b);
      end
      kMOV: dp_rslt = in_a;
      kLD:  dp_rslt = in_a + in_b;
      default: dp_rslt = '0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) state_nxt = start_shift ? SHIFT : DONE;
      end
      SHIFT: begin
        if (sh_done) state_nxt = DONE;
      end
      DONE: begin
        if (accept)         state_nxt = start_shift ? SHIFT : DONE;
        else if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      rslt  <= '0;
      co    <= 1'b0;
      lt    <= 1'b0;
      z     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept && !start_shift) begin
        rslt <= dp_rslt;
        co   <= dp_co;
        lt   <= dp_lt;
        z    <= dp_z;
      end else if (sh_done) begin
        rslt <= sh_nxt;
        co   <= sh_last;
        z    <= (sh_nxt == '0);
      end
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed cases, backpressure, reset mid-shift, random ops, W=16.
module tb_seq_alu;
  import definitions::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  op = '0;
  logic [7:0]  in_a = '0, in_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  rslt;
  logic        co, lt, z;

  logic        in_valid16 = 1'b0;
  logic        in_ready16;
  logic [4:0]  op16 = '0;
  logic [15:0] in_a16 = '0, in_b16 = '0;
  logic        out_valid16;
  logic        out_ready16 = 1'b1;
  logic [15:0] rslt16;
  logic        co16, lt16, z16;

  int tests = 0;
  int fails = 0;

  // reference flag state
  logic m_co = 1'b0, m_lt = 1'b0, m_z = 1'b0;

  always #5 clk = ~clk;

  seq_alu #(.W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .rslt(rslt), .co(co), .lt(lt), .z(z)
  );

  seq_alu #(.W(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16), .op(op16),
    .in_a(in_a16), .in_b(in_b16), .out_valid(out_valid16), .out_ready(out_ready16),
    .rslt(rslt16), .co(co16), .lt(lt16), .z(z16)
  );

  // Reference: result from plain arithmetic, flags updated per opcode, latency in negedge samples
  task automatic model(input logic [4:0] o, input logic [7:0] a, input logic [7:0] b,
                       output logic [7:0] r, output int lat);
    int n;
    int s;
    n   = int'(b) % 8;
    lat = 1;
    r   = 8'h00;
    case (o)
      kADD: begin s = int'(a) + int'(b); r = s[7:0]; m_co = (s > 255); m_z = (r == 0); end
      kADC: begin s = int'(a) + int'(b) + int'(m_co); r = s[7:0]; m_co = (s > 255); m_z = (r == 0); end
      kSUB: begin r = a - b; m_co = (a >= b); m_z = (a == b); end
      kAND: begin r = a & b; m_z = (r == 0); end
      kXOR: begin r = a ^ b; m_z = (r == 0); end
      kSLL: begin r = a << n; if (n > 0) m_co = a[8-n]; m_z = (r == 0); lat = n + 1; end
      kSRL: begin r = a >> n; if (n > 0) m_co = a[n-1]; m_z = (r == 0); lat = n + 1; end
      kCMP: begin r = 8'h00; m_z = (a == b); m_lt = (a < b); end
      kMOV: r = a;
      kLD:  r = a + b;
      default: r = 8'h00;
    endcase
  endtask

  // Called just after a negedge; returns just after the negedge where out_valid is seen
  task automatic run_op(input logic [4:0] o, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] er;
    int elat, lat, low, w;
    model(o, a, b, er, elat);
    op = o; in_a = a; in_b = b; in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 50) begin @(negedge clk); w++; end
    tests++;
    if (!in_ready) begin
      fails++;
      $display("FAIL accept_timeout op=%0d in_ready=%b required 1", o, in_ready);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1 in_valid = 1'b0;
    lat = 0; low = 0;
    while (lat < 50) begin
      @(negedge clk); lat++;
      if (out_valid) break;
      if (!in_ready) low++;
    end
    tests++;
    if (lat !== elat || out_valid !== 1'b1) begin
      fails++;
      $display("FAIL latency op=%0d got=%0d valid=%b required=%0d", o, lat, out_valid, elat);
    end
    tests++;
    if (rslt !== er) begin
      fails++;
      $display("FAIL rslt op=%0d a=%h b=%h got=%h required=%h", o, a, b, rslt, er);
    end
    tests++;
    if ({co, lt, z} !== {m_co, m_lt, m_z}) begin
      fails++;
      $display("FAIL flags op=%0d a=%h b=%h got co/lt/z=%b%b%b required=%b%b%b",
               o, a, b, co, lt, z, m_co, m_lt, m_z);
    end
    tests++;
    if (low !== elat - 1) begin
      fails++;
      $display("FAIL in_ready_low op=%0d got=%0d cycles required=%0d", o, low, elat - 1);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if ({out_valid, in_ready, rslt, co, lt, z} !== {1'b0, 1'b1, 8'h00, 3'b000}) begin
      fails++;
      $display("FAIL reset_state got v=%b r=%b rslt=%h f=%b%b%b required v=0 r=1 rslt=00 f=000",
               out_valid, in_ready, rslt, co, lt, z);
    end
  endtask

  task automatic test_directed();
    run_op(kADD, 8'hF0, 8'h20);
    tests++;
    if ({rslt, co, z} !== {8'h10, 1'b1, 1'b0}) begin
      fails++; $display("FAIL add_const got rslt=%h co=%b z=%b required 10 1 0", rslt, co, z);
    end
    run_op(kADC, 8'h01, 8'h01);
    tests++;
    if ({rslt, co} !== {8'h03, 1'b0}) begin
      fails++; $display("FAIL adc_const got rslt=%h co=%b required 03 0", rslt, co);
    end
    run_op(kSUB, 8'h05, 8'h05);
    run_op(kCMP, 8'h03, 8'h07);
    tests++;
    if ({rslt, co, lt, z} !== {8'h00, 1'b1, 1'b1, 1'b0}) begin
      fails++; $display("FAIL cmp_const got rslt=%h co/lt/z=%b%b%b required 00 110", rslt, co, lt, z);
    end
    run_op(kSLL, 8'h81, 8'd3);
    tests++;
    if ({rslt, co} !== {8'h08, 1'b0}) begin
      fails++; $display("FAIL sll3_const got rslt=%h co=%b required 08 0", rslt, co);
    end
    run_op(kSRL, 8'h81, 8'd1);
    tests++;
    if ({rslt, co} !== {8'h40, 1'b1}) begin
      fails++; $display("FAIL srl1_const got rslt=%h co=%b required 40 1", rslt, co);
    end
    run_op(kSLL, 8'h81, 8'd0);
    run_op(kMOV, 8'h5A, 8'h00);
    run_op(kLD, 8'hFF, 8'h02);
    run_op(5'd31, 8'h12, 8'h34);
  endtask

  task automatic test_backpressure();
    logic [7:0] r0;
    logic [2:0] f0;
    run_op(kXOR, 8'hA5, 8'h0F);
    out_ready = 1'b0;
    r0 = rslt; f0 = {co, lt, z};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++;
      if ({out_valid, in_ready, rslt, co, lt, z} !== {1'b1, 1'b0, r0, f0}) begin
        fails++;
        $display("FAIL backpressure_hold cyc=%0d got v=%b r=%b rslt=%h required v=1 r=0 rslt=%h",
                 i, out_valid, in_ready, rslt, r0);
      end
    end
    out_ready = 1'b1;
    in_valid = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++; $display("FAIL release_accept got in_ready=%b required 1", in_ready);
    end
    run_op(kAND, 8'h3C, 8'h0F);
  endtask

  task automatic test_reset_mid_shift();
    op = kSLL; in_a = 8'h81; in_b = 8'd7; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    m_co = 1'b0; m_lt = 1'b0; m_z = 1'b0;
    @(negedge clk);
    tests++;
    if ({out_valid, in_ready, rslt, co, lt, z} !== {1'b0, 1'b1, 8'h00, 3'b000}) begin
      fails++;
      $display("FAIL reset_mid_shift got v=%b r=%b rslt=%h f=%b%b%b required v=0 r=1 rslt=00 f=000",
               out_valid, in_ready, rslt, co, lt, z);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tests++;
      if (out_valid !== 1'b0) begin
        fails++; $display("FAIL late_completion cyc=%0d got out_valid=%b required 0", i, out_valid);
      end
    end
  endtask

  task automatic test_random();
    logic [4:0] ops [11];
    ops = '{kADD, kADC, kSUB, kAND, kXOR, kSLL, kSRL, kCMP, kMOV, kLD, 5'd20};
    for (int i = 0; i < 150; i++) begin
      run_op(ops[$urandom_range(10)], 8'($urandom), 8'($urandom));
      if ($urandom_range(3) == 0) begin
        out_ready = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        tests++;
        if (out_valid !== 1'b1) begin
          fails++; $display("FAIL random_hold iter=%0d got out_valid=%b required 1", i, out_valid);
        end
        out_ready = 1'b1;
      end
    end
  endtask

  task automatic run16(input logic [4:0] o, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] er, input logic eco, input logic ez, input int elat);
    int lat;
    op16 = o; in_a16 = a; in_b16 = b; in_valid16 = 1'b1;
    @(posedge clk); #1 in_valid16 = 1'b0;
    lat = 0;
    while (lat < 50) begin
      @(negedge clk); lat++;
      if (out_valid16) break;
    end
    tests++;
    if (lat !== elat || {rslt16, co16, z16} !== {er, eco, ez}) begin
      fails++;
      $display("FAIL w16 op=%0d got lat=%0d rslt=%h co=%b z=%b required lat=%0d rslt=%h co=%b z=%b",
               o, lat, rslt16, co16, z16, elat, er, eco, ez);
    end
  endtask

  task automatic test_w16();
    @(negedge clk);
    run16(kADD, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1);
    run16(kSRL, 16'h8000, 16'd15, 16'h0001, 1'b0, 1'b0, 16);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_shift();
    test_random();
    test_w16();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, sequential successor to the datapath ALU. Width is configurable, and a persistent flag register (co, lt, z) is updated per opcode. Adds carry-in addition (ADC), true subtraction, and multi-bit shifts executed iteratively at one bit per cycle. Sits between decode and writeback with a valid/ready handshake on both sides, so multi-cycle ops stall the core cleanly.

## Interface
- W, 8, datapath width; power of two, ≥4
- SHW, $clog2(W), shift-amount width (derived, not overridden)

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  operation offered
- in_ready  out  1  block can accept
- op  in  5  opcode from shared package
- in_a  in  W  operand A
- in_b  in  W  operand B; for shifts only in_b[SHW-1:0] is used
- out_valid  out  1  result held
- out_ready  in  1  consumer takes result
- rslt  out  W  result register
- co, lt, z  out  1 each  flag register outputs

## Operation
- Reset, the rising edge with rst_n=0: state IDLE, rslt=0, co=lt=z=0, out_valid=0, shift counter 0. in_valid is ignored while rst_n=0. Reset mid-shift discards the shift.
- States: IDLE → (accept, non-shift or shift-by-0) → DONE; IDLE → (accept, shift n>0) → SHIFT → (counter hits 0) → DONE; DONE → (out_ready) → IDLE, or straight to a new op if accepting in the same cycle.
- in_ready = (state==IDLE) | (state==DONE & out_ready). in_ready is 0 in SHIFT. Accept = in_valid & in_ready.
- Op semantics; flags not listed hold their value:
  - ADD: {co,rslt}=a+b; z=(rslt==0)
  - ADC: {co,rslt}=a+b+co, using co as held at the accept edge; z updated
  - SUB: {co,rslt}=a+~b+1; co=1 means no borrow (a≥b unsigned); z updated
  - AND, XOR: bitwise; z updated
  - SLL, SRL: logical shift by n=in_b[SHW-1:0]. co = last bit shifted out (n>0 only). z updated.
  - CMP: rslt=0; z=(a==b); lt=(a<b) unsigned; co holds
  - MOV: rslt=a. LD: rslt=a+b. Neither touches flags.
  - Undefined opcode: rslt=0, flags hold, 1-cycle latency
- rslt and flags change only at the completion edge. They hold through SHIFT and through DONE backpressure.

## Timing
- E0 = accept edge.
- Non-shift op: rslt, flags and out_valid are registered at E0. out_valid is high in the cycle after E0.
- Shift by n: at E0 the operand is loaded into the shifter and the counter is set to n. One bit per edge. Completion at edge E0+n, so out_valid is high in the cycle after E0+n. n=0 behaves as a non-shift op.
- Throughput: one op per cycle for back-to-back non-shift ops when out_ready=1.
- DONE with out_ready=0: out_valid, rslt and flags are stable. in_ready=0.
- ADC directly after ADD: the ADC sees the co produced by the ADD, with no hazard.

## Structure
- Shared package `definitions`:
  - Existing opcode constants (kADD, kSUB, kAND, kXOR, kSLL, kSRL, kCMP, kMOV, kLD, …).
  - New kADC.
  - typedef enum {IDLE, SHIFT, DONE} alu_state_t.
- Sub-module `alu_shifter`, parametrised by W:
  - Holds the shift register, down-counter, direction and last-out bit.
  - Ports: load, dir, amount, done pulse.
- Top-level `seq_alu` holds the FSM, the combinational single-cycle datapath, the flag register and the handshake.

## Test plan
- W=8, ADD 8'hF0+8'h20 → rslt=8'h10, co=1, z=0, out_valid in the cycle after accept. Then ADC 8'h01+8'h01 → rslt=8'h03, co=0.
- SUB 8'h05−8'h05 → rslt=0, co=1, z=1. Then CMP 8'h03,8'h07 → lt=1, z=0, rslt=0, co still 1.
- SLL 8'h81 by 3 → rslt=8'h08, co=0; in_ready low for 3 cycles; out_valid after edge E0+3. SRL 8'h81 by 1 → 8'h40, co=1. SLL by 0 → 8'h81, 1-cycle latency, co unchanged.
- Backpressure: hold out_ready=0 for 5 cycles after an op → rslt, flags and out_valid are stable and in_ready=0. Then out_ready=1 with in_valid=1 → the new op is accepted in that same cycle.
- Drive rst_n=0 for one edge during a shift by 7 → next cycle out_valid=0, flags=0, rslt=0, in_ready=1, no late completion.
- W=16: ADD 16'hFFFF+16'h0001 → rslt=0, co=1, z=1. SRL by 15 of 16'h8000 → 16'h0001.
